// File: rtl/tile_line_reader.sv
// ---------------------------------------------------------------------------
// tile_line_reader
//   Display-side reader for the tile memory set. Walks one scanline of the
//   tile map (32x32-pixel tiles), fetching tile index -> pattern word ->
//   palette entry through the read-only port 2 of each memory, and streams
//   24-bit RGB pixels out through a small FIFO.
//
// Ports
//   clk, reset           system clock, asynchronous active-low reset
//   line_start/line_num  one-cycle request to render scanline line_num
//   busy, line_done      line in progress / one-cycle end-of-line pulse
//   tb_*                 tile_buffer port 2    (read-only, 1-cycle latency)
//   tg_*                 tile_graphics port 2  (read-only, 1-cycle latency)
//   pal_*                color_palettes port 2 (read-only, 1-cycle latency)
//   pix_*                pixel stream to the compositor
//   dbg_state            current FSM state (0 = IDLE, 1 = RUN)
//
// Handshake: a pixel transfers on a rising clk edge where pix_valid and
// pix_ready are both high. While pix_valid is high and pix_ready low,
// pix_rgb/pix_x/pix_last hold steady; pix_valid never drops without a
// transfer.
// ---------------------------------------------------------------------------
module tile_line_reader #(
  parameter int H_PIXELS   = 640,
  parameter int V_LINES    = 480,
  parameter int FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        line_start,
  input  logic [8:0]  line_num,
  output logic        busy,
  output logic        line_done,
  output logic        tb_rw,
  output logic [8:0]  tb_addr,
  input  logic [31:0] tb_rdata,
  output logic        tg_rw,
  output logic [10:0] tg_addr,
  input  logic [31:0] tg_rdata,
  output logic        pal_rw,
  output logic [2:0]  pal_addr,
  input  logic [23:0] pal_rdata,
  output logic        pix_valid,
  input  logic        pix_ready,
  output logic [23:0] pix_rgb,
  output logic [9:0]  pix_x,
  output logic        pix_last,
  output logic        dbg_state
);

  localparam int TILES_X = H_PIXELS / 32;
  localparam int AW      = $clog2(FIFO_DEPTH);
  localparam int CW      = AW + 1;
  localparam int OW      = AW + 3;

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t      r_state;
  logic        r_busy;
  logic        r_line_done;
  logic [8:0]  r_y;
  logic [10:0] r_x_issue;

  // Pipeline stage registers: p1 = tile index returning, p2 = pattern word
  // returning, p3 = palette colour returning (pushed into the FIFO).
  logic        r_p1_valid, r_p2_valid, r_p3_valid;
  logic        r_p1_last,  r_p2_last,  r_p3_last;
  logic [9:0]  r_p1_x,     r_p2_x,     r_p3_x;

  logic [23:0]   r_fifo_rgb  [FIFO_DEPTH];
  logic [9:0]    r_fifo_x    [FIFO_DEPTH];
  logic          r_fifo_last [FIFO_DEPTH];
  logic [AW-1:0] r_wr_ptr, r_rd_ptr;
  logic [CW-1:0] r_count;

  logic          w_push, w_pop, w_issue;
  logic [OW-1:0] w_occ;
  logic [3:0]    w_nib;
  logic          w_unused;

  assign w_push = r_p3_valid;
  assign w_pop  = pix_valid && pix_ready;

  // Occupancy counts every pixel already committed to the FIFO: stored
  // entries plus everything still in the memory pipeline. Issuing only while
  // this stays below the depth guarantees the FIFO cannot overflow, and with
  // a depth of 4 or more it still sustains one pixel per cycle.
  assign w_occ = OW'(r_count) + OW'(r_p1_valid) + OW'(r_p2_valid)
               + OW'(r_p3_valid) - OW'(w_pop);

  assign w_issue = (r_state == RUN) && (r_x_issue < 11'(H_PIXELS))
                && (w_occ < OW'(FIFO_DEPTH));

  // Addresses are parked at zero whenever their stage is idle.
  assign tb_addr = w_issue
    ? 9'((32'(r_y) >> 5) * 32'(TILES_X) + (32'(r_x_issue) >> 5))
    : 9'd0;
  assign tg_addr = r_p1_valid ? {tb_rdata[3:0], r_y[4:0], r_p1_x[4:3]} : 11'd0;

  assign w_nib    = tg_rdata[{r_p2_x[2:0], 2'b00} +: 4];
  assign pal_addr = r_p2_valid ? w_nib[2:0] : 3'd0;

  assign tb_rw  = 1'b0;
  assign tg_rw  = 1'b0;
  assign pal_rw = 1'b0;

  assign pix_valid = (r_count != '0);
  assign pix_rgb   = pix_valid ? r_fifo_rgb[r_rd_ptr] : 24'd0;
  assign pix_x     = pix_valid ? r_fifo_x[r_rd_ptr]   : 10'd0;
  assign pix_last  = pix_valid && r_fifo_last[r_rd_ptr];

  assign busy      = r_busy;
  assign line_done = r_line_done;
  assign dbg_state = (r_state == RUN);

  // Upper tile-buffer bits and nibble bit 3 carry no meaning here.
  assign w_unused = ^{tb_rdata[31:4], w_nib[3]};

  // FIFO storage needs no reset: every output read from it is gated by
  // pix_valid, which comes from the reset count.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_rgb[r_wr_ptr]  <= pal_rdata;
      r_fifo_x[r_wr_ptr]    <= r_p3_x;
      r_fifo_last[r_wr_ptr] <= r_p3_last;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_busy      <= 1'b0;
      r_line_done <= 1'b0;
      r_y         <= '0;
      r_x_issue   <= '0;
      r_p1_valid  <= 1'b0;
      r_p2_valid  <= 1'b0;
      r_p3_valid  <= 1'b0;
      r_p1_last   <= 1'b0;
      r_p2_last   <= 1'b0;
      r_p3_last   <= 1'b0;
      r_p1_x      <= '0;
      r_p2_x      <= '0;
      r_p3_x      <= '0;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
    end else begin
      r_line_done <= w_pop && pix_last;

      case (r_state)
        IDLE: begin
          if (line_start && (32'(line_num) < 32'(V_LINES))) begin
            r_state   <= RUN;
            r_busy    <= 1'b1;
            r_y       <= line_num;
            r_x_issue <= '0;
          end
        end
        RUN: begin
          if (w_issue) r_x_issue <= r_x_issue + 11'd1;
          if (w_pop && pix_last) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: r_state <= IDLE;
      endcase

      r_p1_valid <= w_issue;
      r_p1_x     <= r_x_issue[9:0];
      r_p1_last  <= (r_x_issue == 11'(H_PIXELS - 1));
      r_p2_valid <= r_p1_valid;
      r_p2_x     <= r_p1_x;
      r_p2_last  <= r_p1_last;
      r_p3_valid <= r_p2_valid;
      r_p3_x     <= r_p2_x;
      r_p3_last  <= r_p2_last;

      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

endmodule

// File: tb/tb_tile_line_reader.sv
// ---------------------------------------------------------------------------
// tb_tile_line_reader
//   Bench for tile_line_reader: behavioural models of the three memories,
//   a reference pixel model, and one task per scenario.
// ---------------------------------------------------------------------------
module tb_tile_line_reader;

  localparam int H = 640;
  localparam int V = 480;
  localparam int D = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset = 1'b0;
  logic        line_start = 1'b0;
  logic [8:0]  line_num = '0;
  logic        busy, line_done, dbg_state;
  logic        tb_rw, tg_rw, pal_rw;
  logic [8:0]  tb_addr;
  logic [10:0] tg_addr;
  logic [2:0]  pal_addr;
  logic [31:0] tb_rdata = '0;
  logic [31:0] tg_rdata = '0;
  logic [23:0] pal_rdata = '0;
  logic        pix_valid, pix_last;
  logic        pix_ready = 1'b0;
  logic [23:0] pix_rgb;
  logic [9:0]  pix_x;

  tile_line_reader #(.H_PIXELS(H), .V_LINES(V), .FIFO_DEPTH(D)) dut (
    .clk(clk), .reset(reset), .line_start(line_start), .line_num(line_num),
    .busy(busy), .line_done(line_done),
    .tb_rw(tb_rw), .tb_addr(tb_addr), .tb_rdata(tb_rdata),
    .tg_rw(tg_rw), .tg_addr(tg_addr), .tg_rdata(tg_rdata),
    .pal_rw(pal_rw), .pal_addr(pal_addr), .pal_rdata(pal_rdata),
    .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_rgb(pix_rgb),
    .pix_x(pix_x), .pix_last(pix_last), .dbg_state(dbg_state)
  );

  // ---------------- memory models (1-cycle read latency) ----------------
  logic [31:0] tb_mem  [512];
  logic [31:0] tg_mem  [2048];
  logic [23:0] pal_mem [8];

  always @(posedge clk) begin
    tb_rdata  <= tb_mem[tb_addr];
    tg_rdata  <= tg_mem[tg_addr];
    pal_rdata <= pal_mem[pal_addr];
  end

  // ---------------- observers ----------------
  int          max_fifo = 0;
  logic [8:0]  last_tb  = '0;
  logic [10:0] last_tg  = '0;

  always @(negedge clk) begin
    if (int'(dut.r_count) > max_fifo) max_fifo = int'(dut.r_count);
    if (tb_addr != 9'd0)  last_tb = tb_addr;
    if (tg_addr != 11'd0) last_tg = tg_addr;
  end

  // ---------------- scoreboard ----------------
  logic [34:0] exp_q[$];
  logic [34:0] got_q[$];
  int n_vec = 0;
  int n_err = 0;

  function automatic logic [34:0] model_pix(input int y, input int x);
    int tile, gaddr, nib;
    logic [3:0]  pat;
    logic [31:0] word;
    tile  = (y / 32) * (H / 32) + x / 32;
    pat   = tb_mem[tile][3:0];
    gaddr = int'(pat) * 128 + (y % 32) * 4 + (x % 32) / 8;
    word  = tg_mem[gaddr];
    nib   = int'((word >> (4 * (x % 8))) & 32'hF);
    return {(x == H - 1), 10'(x), pal_mem[nib % 8]};
  endfunction

  task automatic push_line(input int y);
    for (int x = 0; x < H; x++) exp_q.push_back(model_pix(y, x));
  endtask

  task automatic randomize_mems();
    for (int i = 0; i < 512; i++)  tb_mem[i]  = $urandom();
    for (int i = 0; i < 2048; i++) tg_mem[i]  = $urandom();
    for (int i = 0; i < 8; i++)    pal_mem[i] = 24'($urandom());
  endtask

  // ---------------- driver tasks ----------------
  task automatic start_line(input int y);
    @(negedge clk);
    line_num   = 9'(y);
    line_start = 1'b1;
    @(negedge clk);
    line_start = 1'b0;
  endtask

  // Drives pix_ready at duty% and records every accepted pixel into got_q.
  // Returns at line_done (optionally chaining a new line_start into that
  // cycle), after max_pix acceptances, or when the cycle budget runs out.
  task automatic collect(input int duty, input int max_pix, input int chain_y,
                         output int done_cnt, output int done_bad,
                         output int bubbles, output int timed_out);
    int acc, cyc, post_last;
    bit prev_last, started, seen_last;
    acc = 0; cyc = 0; post_last = 0;
    prev_last = 0; started = 0; seen_last = 0;
    done_cnt = 0; done_bad = 0; bubbles = 0; timed_out = 0;
    forever begin
      @(negedge clk);
      if (acc >= max_pix) begin
        pix_ready = 1'b0;
        break;
      end
      if (cyc >= 20000 || post_last > 5) begin
        timed_out = 1;
        break;
      end
      cyc++;
      if (seen_last) post_last++;
      if (line_done === 1'b1) begin
        done_cnt++;
        if (!prev_last || busy !== 1'b0) done_bad++;
        if (chain_y >= 0) begin
          line_num   = 9'(chain_y);
          line_start = 1'b1;
        end
        break;
      end
      if (started && !seen_last && pix_valid !== 1'b1) bubbles++;
      pix_ready = ($urandom_range(99) < duty);
      prev_last = 0;
      if (pix_valid === 1'b1 && pix_ready === 1'b1) begin
        got_q.push_back({pix_last, pix_x, pix_rgb});
        acc++;
        started = 1;
        if (pix_last === 1'b1) begin
          seen_last = 1;
          prev_last = 1;
        end
      end
    end
  endtask

  // ---------------- scenario tasks ----------------
  task automatic test_reset();
    int bad;
    reset = 1'b0; line_start = 1'b1; line_num = 9'd0; pix_ready = 1'b1;
    repeat (3) @(negedge clk);
    n_vec++;
    if ({busy, pix_valid, line_done, pix_last} !== 4'b0000) begin
      n_err++;
      $display("FAIL reset_flags got %b want 0000", {busy, pix_valid, line_done, pix_last});
    end
    n_vec++;
    if (tb_addr !== 9'd0 || tg_addr !== 11'd0 || pal_addr !== 3'd0 ||
        pix_rgb !== 24'd0 || pix_x !== 10'd0) begin
      n_err++;
      $display("FAIL reset_data tb=%h tg=%h pal=%h rgb=%h x=%h want all 0",
               tb_addr, tg_addr, pal_addr, pix_rgb, pix_x);
    end
    n_vec++;
    if ({tb_rw, tg_rw, pal_rw} !== 3'b000) begin
      n_err++;
      $display("FAIL rw_const got %b want 000", {tb_rw, tg_rw, pal_rw});
    end
    line_start = 1'b0;
    reset = 1'b1;
    bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (tb_addr !== 9'd0 || busy !== 1'b0 || pix_valid !== 1'b0) bad++;
    end
    n_vec++;
    if (bad != 0) begin
      n_err++;
      $display("FAIL reset_quiet got %0d active cycles want 0", bad);
    end
  endtask

  task automatic test_basic();
    logic [23:0] want_rgb[8];
    logic [34:0] g, e;
    int lat, dc, db, bb, to, mis;
    for (int i = 0; i < 512; i++)  tb_mem[i] = '0;
    for (int i = 0; i < 2048; i++) tg_mem[i] = '0;
    for (int i = 0; i < 8; i++)    pal_mem[i] = 24'(32'h111111 * i);
    tb_mem[0]   = 32'd1;
    tg_mem[128] = 32'hF6543210;
    want_rgb = '{24'h000000, 24'h111111, 24'h222222, 24'h333333,
                 24'h444444, 24'h555555, 24'h666666, 24'h777777};
    push_line(0);

    @(negedge clk);
    line_num = 9'd0; line_start = 1'b1; pix_ready = 1'b1;
    @(posedge clk);
    #1 line_start = 1'b0;
    n_vec++;
    if (busy !== 1'b1) begin
      n_err++;
      $display("FAIL basic_busy got %b want 1", busy);
    end
    lat = 0;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk);
      #1;
      if (pix_valid === 1'b1) begin
        lat = k;
        break;
      end
    end
    n_vec++;
    if (lat != 4) begin
      n_err++;
      $display("FAIL basic_latency got %0d edges want 4", lat);
    end

    collect(100, 100000, -1, dc, db, bb, to);
    if (got_q.size() >= 8) begin
      for (int i = 0; i < 8; i++) begin
        n_vec++;
        if (got_q[i][23:0] !== want_rgb[i]) begin
          n_err++;
          $display("FAIL basic_rgb x=%0d got %h want %h", i, got_q[i][23:0], want_rgb[i]);
        end
      end
    end
    n_vec++;
    if (got_q.size() != exp_q.size()) begin
      n_err++;
      $display("FAIL basic_count got %0d want %0d", got_q.size(), exp_q.size());
    end
    mis = 0;
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front();
      e = exp_q.pop_front();
      n_vec++;
      if (g !== e) begin
        n_err++;
        if (mis < 5) $display("FAIL basic_pix got %h want %h", g, e);
        mis++;
      end
    end
    n_vec++;
    if (dc != 1 || db != 0 || to != 0) begin
      n_err++;
      $display("FAIL basic_done got done=%0d bad=%0d timeout=%0d want 1/0/0", dc, db, to);
    end
    n_vec++;
    if (bb != 0) begin
      n_err++;
      $display("FAIL basic_bubbles got %0d want 0", bb);
    end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_addressing();
    logic [34:0] g, e;
    int dc, db, bb, to, mis, bad;
    logic [10:0] want_tg;
    randomize_mems();
    want_tg = 11'(int'(tb_mem[299][3:0]) * 128 + 31 * 4 + 3);
    push_line(479);
    last_tb = '0; last_tg = '0;
    start_line(479);
    collect(100, 100000, -1, dc, db, bb, to);
    n_vec++;
    if (last_tb !== 9'd299) begin
      n_err++;
      $display("FAIL addr_tb got %0d want 299", last_tb);
    end
    n_vec++;
    if (last_tg !== want_tg) begin
      n_err++;
      $display("FAIL addr_tg got %0d want %0d", last_tg, want_tg);
    end
    n_vec++;
    if (got_q.size() != exp_q.size() || dc != 1 || db != 0 || bb != 0) begin
      n_err++;
      $display("FAIL addr_line got n=%0d done=%0d bad=%0d bub=%0d want %0d/1/0/0",
               got_q.size(), dc, db, bb, exp_q.size());
    end
    mis = 0;
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front();
      e = exp_q.pop_front();
      n_vec++;
      if (g !== e) begin
        n_err++;
        if (mis < 5) $display("FAIL addr_pix got %h want %h", g, e);
        mis++;
      end
    end
    exp_q.delete(); got_q.delete();

    start_line(480);
    bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (busy !== 1'b0 || pix_valid !== 1'b0 || tb_addr !== 9'd0) bad++;
    end
    n_vec++;
    if (bad != 0) begin
      n_err++;
      $display("FAIL addr_ignore480 got %0d active cycles want 0", bad);
    end
  endtask

  task automatic test_backpressure();
    logic [34:0] g, e;
    int dc, db, bb, to, mis;
    randomize_mems();
    push_line(37);
    start_line(37);
    max_fifo = 0;
    collect(30, 100000, -1, dc, db, bb, to);
    n_vec++;
    if (got_q.size() != 640) begin
      n_err++;
      $display("FAIL bp_count got %0d want 640", got_q.size());
    end
    mis = 0;
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front();
      e = exp_q.pop_front();
      n_vec++;
      if (g !== e) begin
        n_err++;
        if (mis < 5) $display("FAIL bp_pix got %h want %h", g, e);
        mis++;
      end
    end
    n_vec++;
    if (max_fifo > D) begin
      n_err++;
      $display("FAIL bp_fifo_max got %0d want <= %0d", max_fifo, D);
    end
    n_vec++;
    if (dc != 1 || db != 0 || to != 0) begin
      n_err++;
      $display("FAIL bp_done got done=%0d bad=%0d timeout=%0d want 1/0/0", dc, db, to);
    end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_back_to_back();
    logic [34:0] g, e;
    int dc, db, bb, to, dc2, db2, bb2, to2, mis;
    randomize_mems();
    push_line(10);
    push_line(11);
    start_line(10);
    pix_ready = 1'b0;
    repeat (3) @(negedge clk);
    start_line(20);
    collect(100, 100000, 11, dc, db, bb, to);
    @(negedge clk);
    line_start = 1'b0;
    n_vec++;
    if (busy !== 1'b1) begin
      n_err++;
      $display("FAIL b2b_restart got busy=%b want 1", busy);
    end
    collect(60, 100000, -1, dc2, db2, bb2, to2);
    n_vec++;
    if (got_q.size() != 1280) begin
      n_err++;
      $display("FAIL b2b_count got %0d want 1280", got_q.size());
    end
    mis = 0;
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front();
      e = exp_q.pop_front();
      n_vec++;
      if (g !== e) begin
        n_err++;
        if (mis < 5) $display("FAIL b2b_pix got %h want %h", g, e);
        mis++;
      end
    end
    n_vec++;
    if (dc != 1 || db != 0 || to != 0 || dc2 != 1 || db2 != 0 || to2 != 0) begin
      n_err++;
      $display("FAIL b2b_done got %0d/%0d/%0d %0d/%0d/%0d want 1/0/0 1/0/0",
               dc, db, to, dc2, db2, to2);
    end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_reset_mid();
    logic [34:0] g, e;
    int dc, db, bb, to, mis, bad;
    randomize_mems();
    push_line(50);
    start_line(50);
    collect(100, 200, -1, dc, db, bb, to);
    reset = 1'b0;
    #1;
    n_vec++;
    if ({busy, pix_valid, pix_last, line_done} !== 4'b0000 ||
        pix_rgb !== 24'd0 || pix_x !== 10'd0) begin
      n_err++;
      $display("FAIL midreset_clear got flags=%b rgb=%h x=%0d want 0",
               {busy, pix_valid, pix_last, line_done}, pix_rgb, pix_x);
    end
    n_vec++;
    if (got_q.size() != 200) begin
      n_err++;
      $display("FAIL midreset_count got %0d want 200", got_q.size());
    end
    mis = 0;
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front();
      e = exp_q.pop_front();
      n_vec++;
      if (g !== e) begin
        n_err++;
        if (mis < 5) $display("FAIL midreset_pix got %h want %h", g, e);
        mis++;
      end
    end
    exp_q.delete(); got_q.delete();
    repeat (2) @(negedge clk);
    reset = 1'b1;
    pix_ready = 1'b1;
    bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (pix_valid !== 1'b0 || line_done !== 1'b0 || busy !== 1'b0) bad++;
    end
    n_vec++;
    if (bad != 0) begin
      n_err++;
      $display("FAIL midreset_stale got %0d active cycles want 0", bad);
    end

    push_line(5);
    start_line(5);
    collect(100, 100000, -1, dc, db, bb, to);
    n_vec++;
    if (got_q.size() != 640 || dc != 1 || db != 0 || to != 0) begin
      n_err++;
      $display("FAIL line5 got n=%0d done=%0d bad=%0d to=%0d want 640/1/0/0",
               got_q.size(), dc, db, to);
    end
    mis = 0;
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front();
      e = exp_q.pop_front();
      n_vec++;
      if (g !== e) begin
        n_err++;
        if (mis < 5) $display("FAIL line5_pix got %h want %h", g, e);
        mis++;
      end
    end
    exp_q.delete(); got_q.delete();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_basic();
    test_addressing();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired before summary");
    $fatal(1);
  end

endmodule

// File: doc/tile_line_reader.md
Name: tile_line_reader

Overview:
- Display-side reader for the tile memory set. The CPU writes tile_buffer, tile_graphics and color_palettes through port 1; this block owns port 2 of all three, read-only.
- On a line request it walks one scanline of the 20x15 tile map (32x32-pixel tiles). It fetches tile index, then pattern word, then palette entry.
- It streams 24-bit RGB pixels to the VGA/compositor side under a valid/ready handshake.

Parameters:
- H_PIXELS, 640, visible pixels per line; must be a multiple of 32.
- V_LINES, 480, visible lines; must be a multiple of 32.
- FIFO_DEPTH, 8, output pixel FIFO entries; must be a power of 2 and at least 4.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- line_start  in  1  one-cycle request to render line line_num
- line_num  in  9  scanline 0..V_LINES-1, sampled with line_start
- busy  out  1  line in progress
- line_done  out  1  one-cycle pulse after the last pixel of a line is accepted
- tb_rw  out  1  tile_buffer port-2 rw; constant 0
- tb_addr  out  9  tile_buffer port-2 address
- tb_rdata  in  32  tile_buffer port-2 read data; 1-cycle latency; bits[3:0] = pattern index
- tg_rw  out  1  tile_graphics port-2 rw; constant 0
- tg_addr  out  11  tile_graphics port-2 address
- tg_rdata  in  32  tile_graphics port-2 read data; 1-cycle latency
- pal_rw  out  1  color_palettes port-2 rw; constant 0
- pal_addr  out  3  palette port-2 address
- pal_rdata  in  24  palette port-2 read data; 1-cycle latency
- pix_valid  out  1  pixel available
- pix_ready  in  1  consumer accepts pixel when pix_valid and pix_ready are both high
- pix_rgb  out  24  pixel colour
- pix_x  out  10  x coordinate of pix_rgb
- pix_last  out  1  high with pixel x = H_PIXELS-1

Behaviour:
- Reset (reset low, asynchronous) clears all state. busy, line_done, pix_valid and pix_last = 0. pix_rgb, pix_x, all addresses = 0. FIFO and pipeline are emptied.
- Reset mid-line aborts the line: no line_done, and no stale pixels are emitted after release.
- FSM states are IDLE and RUN.
  - In IDLE, line_start with line_num < V_LINES latches y and sets x_issue=0. Next state is RUN, and busy rises at that edge.
  - line_start with line_num >= V_LINES is ignored.
  - line_start while busy is ignored.
- Address formation:
  - Tile address: tb_addr = (y>>5)*(H_PIXELS/32) + (x>>5).
  - Pattern word: tg_addr = {pattern[3:0], y[4:0], x[4:3]} = pattern*128 + (y&31)*4 + ((x&31)>>3).
  - Nibble select: nibble = tg_rdata[4*(x&7)+3 : 4*(x&7)], and pal_addr = nibble[2:0]; nibble bit 3 is ignored.
  - All intermediate widths truncate, with no saturation.
- Pipeline, one pixel per stage:
  - S0: tb_addr issued.
  - S1: tb_rdata valid, tg_addr driven from it.
  - S2: tg_rdata valid, pal_addr driven.
  - S3: pal_rdata valid, written to the FIFO with x.
  - x and the last flag are carried alongside each stage.
- Latency: with an empty FIFO, the first pix_valid rises 4 edges after the edge that sampled line_start.
- Issue rule, evaluated every RUN cycle: issue pixel x_issue iff x_issue < H_PIXELS and (fifo_count + inflight − pop_this_cycle) < FIFO_DEPTH.
  - inflight is the number of valid S0..S2 stages.
  - This never overflows the FIFO.
  - With pix_ready held high it sustains 1 pixel per cycle, with no bubbles after the first pixel.
- Output side:
  - pix_valid = FIFO not empty.
  - pix_rgb, pix_x and pix_last come from the FIFO head and are held stable while pix_valid && !pix_ready.
  - Pixels leave in strictly increasing x order.
- End of line: when the pixel with pix_last is accepted:
  - line_done pulses high during the next cycle;
  - busy falls at the same edge line_done rises;
  - the FSM returns to IDLE.
- line_start in the line_done cycle is accepted: the FSM re-enters RUN.
- Backpressure: pix_ready may be low for any duration. The FIFO is then full, issue stalls, and no pixels are lost or duplicated.

Test Plan:
- Reset: hold reset low 3 cycles with line_start=1 -> busy, pix_valid, line_done, pix_last = 0; no tb_addr activity after release until a new line_start.
- Basic pixels:
  - Setup: tile_buffer[0]=1, tile_graphics[128]=0xF6543210, palette[i]=0x111111*i; line_start with line_num=0, pix_ready=1.
  - Required: first pix_valid 4 edges later; x=0..7 give rgb 0x000000, 0x111111, … 0x666666, then 0x777777 for x=7 (nibble F→7).
  - Required: 640 consecutive accepted pixels; line_done one cycle after pix_last.
- Addressing: line_num=479, x=639 -> tb_addr=299, tg_addr=pattern*128+31*4+3; line_num=480 -> ignored, busy stays 0.
- Backpressure: random pix_ready with 30% duty over line 37 -> exactly 640 pixels, x in order, rgb matches the model, FIFO count never exceeds 8.
- Ignored and back-to-back requests: line_start during busy -> ignored; line_start in the line_done cycle -> next line starts with no pixel loss.
- Reset mid-line: assert reset at pixel 200 -> outputs clear at once; new line 5 renders fully and correctly.
